// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - CHIP-8 system RAM arbiter between video fetch and CPU
//
// Purpose: shares one sync-read (1-cycle latency) single-port RAM between the
// pixel fetch path and the CPU. Video owns the RAM during active display; the
// CPU is served freely in blanking, and a starvation counter steals one video
// slot after MAX_WAIT cycles of CPU waiting.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   video_on, vid_addr  video fetch request (one byte address per pixel)
//   vid_data            byte for the previous cycle's vid_addr
//   cpu_req/we/addr/wdata  CPU request, held stable until cpu_grant
//   cpu_grant           combinational; CPU access presented to RAM this cycle
//   cpu_rdata/rvalid    CPU read return, one cycle after the read grant
//   mem_addr/we/wdata   RAM request side
//   mem_rdata           RAM read data, one cycle after mem_addr
module vram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_on,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_grant,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, VID, CPU_RD, CPU_WR} owner_t;

  owner_t     owner_q;
  owner_t     owner_d;
  logic [7:0] wait_cnt;
  logic [7:0] vid_hold;
  logic       steal;
  logic       cpu_win;

  assign steal = (wait_cnt == 8'(MAX_WAIT));

  // Reset gates the win so no write or grant can leak out while reset is high.
  assign cpu_win = cpu_req & (~video_on | steal) & ~reset;

  assign cpu_grant = cpu_win;
  assign mem_addr  = cpu_win ? cpu_addr : vid_addr;
  assign mem_we    = cpu_win & cpu_we;
  assign mem_wdata = cpu_win ? cpu_wdata : 8'h00;

  always_comb begin
    owner_d = IDLE;
    if (cpu_win)
      owner_d = cpu_we ? CPU_WR : CPU_RD;
    else if (video_on)
      owner_d = VID;
  end

  assign cpu_rdata = mem_rdata;

  // When the previous slot was not a video read (stolen or idle), repeat the
  // last byte shown so the pixel stream never sees CPU data.
  assign vid_data = (owner_q == VID) ? mem_rdata : vid_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= IDLE;
      cpu_rvalid <= 1'b0;
      wait_cnt   <= 8'h00;
      vid_hold   <= 8'h00;
    end else begin
      owner_q    <= owner_d;
      cpu_rvalid <= (owner_d == CPU_RD);
      vid_hold   <= vid_data;
      if (cpu_win || !cpu_req)
        wait_cnt <= 8'h00;
      else if (!steal)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

  localparam int ADDR_W   = 12;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              preload;
  logic              video_on;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_grant;
  logic [7:0]        cpu_rdata;
  logic              cpu_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0] ram    [0:4095];
  logic [7:0] shadow [0:4095];

  int   total = 0;
  int   bad   = 0;
  int   m_wait;
  bit   m_rv;
  logic [7:0] m_rdata;
  logic [7:0] m_vid;
  bit   dut_g;
  int   gcyc;
  int   gq[$];
  int   d0;
  int   d1;

  vram_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .vid_addr(vid_addr),
    .vid_data(vid_data), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_grant(cpu_grant),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 4096; k++) ram[k] <= 8'(k);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven. Reference rules: the CPU wins
  // when it asks in blanking or after waiting MAX_WAIT cycles; video shows the
  // byte of the last address it actually read.
  task automatic cycle();
    bit g;
    #1;
    g = cpu_req && (!video_on || m_wait >= MAX_WAIT);
    dut_g = cpu_grant;
    chk("grant", cpu_grant, g);
    chk("mem_we", mem_we, g && cpu_we);
    chk("mem_addr", mem_addr, g ? cpu_addr : vid_addr);
    if (g && cpu_we) chk("mem_wdata", mem_wdata, cpu_wdata);
    m_rv = 0;
    if (g) begin
      if (cpu_we) shadow[cpu_addr] = cpu_wdata;
      else begin
        m_rv    = 1;
        m_rdata = shadow[cpu_addr];
      end
      m_wait = 0;
    end else if (cpu_req) begin
      m_wait++;
    end else begin
      m_wait = 0;
    end
    if (!g && video_on) m_vid = shadow[vid_addr];
    @(posedge clk);
    #1;
    chk("rvalid", cpu_rvalid, m_rv);
    if (m_rv) chk("rdata", cpu_rdata, m_rdata);
    chk("vid_data", vid_data, m_vid);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    video_on = 1'b0;
    #1;
    chk("rst_rvalid", cpu_rvalid, 1'b0);
    chk("rst_vid", vid_data, 8'h00);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_grant", cpu_grant, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_grant", cpu_grant, 1'b0);
    chk("rst_hold_vid", vid_data, 8'h00);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    reset   = 1'b0;
    m_wait  = 0;
    m_rv    = 0;
    m_vid   = 8'h00;
  endtask

  initial begin
    reset     = 1'b1;
    preload   = 1'b1;
    video_on  = 1'b0;
    vid_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = 8'h00;
    for (int k = 0; k < 4096; k++) shadow[k] = 8'(k);
    @(posedge clk);
    #1;
    preload = 1'b0;
    apply_reset();

    // Blanking write then read of 0x200.
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h200; cpu_wdata = 8'hA5;
    cycle();
    chk("wr_grant", dut_g, 1'b1);
    chk("wr_no_rvalid", cpu_rvalid, 1'b0);
    cpu_we = 0;
    cycle();
    chk("rd_grant", dut_g, 1'b1);
    chk("rd_rvalid", cpu_rvalid, 1'b1);
    chk("rd_data", cpu_rdata, 8'hA5);
    cpu_req = 0;
    cycle();

    // Video sweep, no CPU traffic.
    video_on = 1;
    for (int i = 0; i < 64; i++) begin
      vid_addr = 12'h100 + 12'(i);
      cycle();
      chk("sweep_byte", vid_data, 8'(i));
    end

    // Steal: read held from cycle 0 during active video.
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h120; gcyc = -1;
    for (int i = 0; i < 40 && gcyc < 0; i++) begin
      vid_addr = 12'h140 + 12'(i);
      cycle();
      if (dut_g) gcyc = i;
    end
    chk("steal_cycle", gcyc, MAX_WAIT);
    chk("steal_rvalid", cpu_rvalid, 1'b1);
    chk("steal_rdata", cpu_rdata, 8'h20);

    // Request held across three more grants: spacing MAX_WAIT+1.
    for (int i = 0; i < 60; i++) begin
      vid_addr = 12'($urandom);
      cycle();
      if (dut_g) begin
        gq.push_back(i);
        cpu_addr = 12'($urandom_range(0, 255));
      end
    end
    chk("held_grants", gq.size(), 3);
    d0 = (gq.size() >= 2) ? gq[1] - gq[0] : -1;
    d1 = (gq.size() >= 3) ? gq[2] - gq[1] : -1;
    chk("first_gap", (gq.size() >= 1) ? gq[0] : -1, MAX_WAIT);
    chk("gap0", d0, MAX_WAIT + 1);
    chk("gap1", d1, MAX_WAIT + 1);

    // CPU waits 5 cycles, then video_on falls.
    cpu_req = 0;
    cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h200;
    for (int i = 0; i < 5; i++) begin
      vid_addr = 12'h010 + 12'(i);
      cycle();
      chk("fall_wait", dut_g, 1'b0);
    end
    video_on = 0;
    cycle();
    chk("fall_grant", dut_g, 1'b1);
    video_on = 1; gcyc = -1;
    for (int i = 0; i < 20 && gcyc < 0; i++) begin
      cycle();
      if (dut_g) gcyc = i;
    end
    chk("fall_cnt_cleared", gcyc, MAX_WAIT);
    cpu_req = 0;

    // Reset one cycle after a read grant.
    video_on = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h200;
    cycle();
    apply_reset();
    cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h200;
    cycle();
    chk("post_rst_grant", dut_g, 1'b1);
    chk("post_rst_rdata", cpu_rdata, 8'hA5);
    cpu_req = 0;

    // Randomized traffic.
    video_on = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) video_on = ~video_on;
      vid_addr = 12'($urandom);
      if (!cpu_req) begin
        if ($urandom_range(0, 3) == 0) begin
          cpu_req   = 1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = 12'($urandom_range(0, 255));
          cpu_wdata = 8'($urandom);
        end
      end else if ($urandom_range(0, 29) == 0) begin
        cpu_req = 0;
      end
      cycle();
      if (dut_g) cpu_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port CHIP-8 system RAM (sync read, 1-cycle latency) between the video fetch path and the CPU core.
- The video fetch path issues one byte address per pixel clock while video_on is high. The CPU issues read/write requests through a req/grant handshake.
- Video has priority during active display. The CPU is served freely during blanking, and a starvation counter forces a CPU slot during long active periods.
- Sits between pixel_generator, the CPU, and the RAM instance.

Parameters:
- ADDR_W, 12, RAM byte-address width (4 KiB CHIP-8 space).
- MAX_WAIT, 15, CPU wait cycles before a slot is stolen from video; range 1..255.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- video_on  in  1  high during active display; video owns RAM unless a steal occurs
- vid_addr  in  ADDR_W  byte address from pixel generator, sampled by RAM this cycle
- vid_data  out  8  byte for the vid_addr of the previous cycle
- cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_grant
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_grant  out  1  combinational; high in the cycle the CPU access is presented to RAM
- cpu_rdata  out  8  read data, valid when cpu_rvalid
- cpu_rvalid  out  1  registered; 1-cycle pulse the cycle after a granted read
- mem_addr  out  ADDR_W  RAM address (combinational mux)
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, 1 cycle after mem_addr

Behaviour:

Slot decision (combinational, every cycle):
- cpu_win = cpu_req & (~video_on | steal).
- steal = (wait_cnt == MAX_WAIT).
- cpu_win=1: mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata, cpu_grant = 1.
- cpu_win=0: mem_addr = vid_addr, mem_we = 0, mem_wdata = 0, cpu_grant = 0.
- While reset is high: mem_we = 0 and cpu_grant = 0, regardless of other inputs.

Owner FSM, owner_q registered with states IDLE, VID, CPU_RD, CPU_WR:
- Next state is CPU_RD or CPU_WR if cpu_win, by cpu_we.
- Else VID if video_on.
- Else IDLE.

Return path:
- cpu_rvalid <= (next state == CPU_RD).
- cpu_rdata = mem_rdata, combinational; meaningful only when cpu_rvalid.
- vid_data = (owner_q == VID) ? mem_rdata : vid_hold.
- vid_hold <= vid_data every cycle. A stolen slot therefore repeats the previous video byte for one pixel; this is accepted.

Starvation counter wait_cnt (8 bit):
- Cleared on cpu_grant or when cpu_req = 0.
- Increments each cycle with cpu_req & ~cpu_grant.
- Saturates at MAX_WAIT.

Boundary cases:
- Back-to-back CPU requests in blanking: one grant per cycle, cpu_req may stay high.
- During video_on, each grant resets the counter, so steals are spaced by at least MAX_WAIT+1 cycles.
- video_on falling while the CPU is waiting: grant in the first blanking cycle.
- video_on rising in the same cycle as a CPU grant: the CPU still wins (decision uses the current video_on).
- Simultaneous steal and video_on: the CPU wins, and vid_data holds for exactly one cycle.
- A write never produces cpu_rvalid.
- cpu_req dropped before grant: no access, counter cleared.

Reset values:
- owner_q = IDLE, wait_cnt = 0, vid_hold = 8'h00, cpu_rvalid = 0.
- Combinational outputs follow from these: vid_data = 0, cpu_grant = 0, mem_we = 0.
- Reset mid-access: pending rvalid is dropped; the CPU must re-request.

Latency:
- CPU read: grant cycle N, cpu_rvalid/cpu_rdata in cycle N+1.
- Video: data one cycle after address, as for direct RAM.

Test Plan:
- Blanking (video_on=0), CPU writes 8'hA5 to 12'h200, then reads 12'h200 -> grant same cycle as req both times; cpu_rvalid=1 one cycle after the read grant with cpu_rdata=8'hA5; no rvalid after the write.
- video_on=1, RAM preloaded with addr k = k[7:0], vid_addr sweeps 12'h100..12'h13F, no CPU traffic -> vid_data equals previous-cycle address low byte every cycle; mem_we never asserted.
- video_on=1, cpu_req read held from cycle 0 -> cpu_grant first in cycle MAX_WAIT (15); that cycle's video byte replaced by a repeat of cycle 14's byte in cycle 16; cpu_rvalid in cycle 16.
- video_on=1 with cpu_req held continuously across 3 grants -> grants spaced exactly 16 cycles apart; wait_cnt never exceeds 15.
- CPU waiting 5 cycles when video_on falls -> grant in the first video_on=0 cycle; wait_cnt returns to 0.
- Assert reset one cycle after a read grant -> cpu_rvalid=0, vid_data=0, mem_we=0 immediately (async); after release, owner_q=IDLE and a new request is granted normally.
